// File: rtl/ext_ram_responder.sv
// ext_ram_responder: block-RAM backed responder for the word-addressed ram_* bus.
// It inserts a programmable number of wait states before each command and returns
// read data after a fixed latency. It also caps the number of reads in flight.
module ext_ram_responder #(
    parameter int RAM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int WAIT_CYCLES    = 1,
    parameter int READ_LATENCY   = 3,
    parameter int MAX_PENDING    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [RAM_ADDR_WIDTH-1:0] ram_address,
    input  logic [DATA_WIDTH/8-1:0]   ram_byteenable_n,
    input  logic                      ram_chipselect,
    input  logic [DATA_WIDTH-1:0]     ram_writedata,
    input  logic                      ram_read_n,
    input  logic                      ram_write_n,
    output logic [DATA_WIDTH-1:0]     ram_readdata,
    output logic                      ram_readdatavalid,
    output logic                      ram_waitrequest
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_CYCLES);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    logic [DATA_WIDTH-1:0]   mem_q [2**RAM_ADDR_WIDTH];
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] wcnt_d;
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;
    logic [PEND_W-1:0] pend_eff_s;
    logic              cmd_s;
    logic              is_wr_s;
    logic              ready_s;
    logic              acc_s;
    logic              wr_acc_s;
    logic              rd_acc_s;

    // Command decode, acceptance, stall and next-state of the wait and pending counters.
    always_comb begin
        cmd_s      = ram_chipselect & (~ram_read_n | ~ram_write_n);
        is_wr_s    = ~ram_write_n;
        // A read retiring this cycle frees its slot for a read accepted in the same cycle.
        pend_eff_s = pend_q - PEND_W'(ram_readdatavalid);
        ready_s    = (wcnt_q == WCNT_MAX) & (is_wr_s | (pend_eff_s < PEND_MAX));
        acc_s      = cmd_s & ready_s & ~reset;
        wr_acc_s   = acc_s & is_wr_s;
        rd_acc_s   = acc_s & ~is_wr_s;
        ram_waitrequest = reset | (cmd_s & ~acc_s);

        wcnt_d = wcnt_q;
        if (acc_s) begin
            wcnt_d = '0;
        end else if (cmd_s & ~ready_s & (wcnt_q < WCNT_MAX)) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end else begin
            // A dropped command keeps its progress so a re-presented command is not delayed again.
            wcnt_d = wcnt_q;
        end

        pend_d = pend_q + PEND_W'(rd_acc_s) - PEND_W'(ram_readdatavalid);
    end

    // Wait-state and outstanding-read counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= '0;
            pend_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            pend_q <= pend_d;
        end
    end

    // Byte-lane writes into the memory array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            for (int b = 0; b < BE_W; b++) begin
                if (!ram_byteenable_n[b]) begin
                    mem_q[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
                end
            end
        end
    end

    // Read-return pipeline: stage 0 captures the word at acceptance, last stage drives the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            vld_q[0] <= rd_acc_s;
            dat_q[0] <= mem_q[ram_address];
        end
    end

    assign ram_readdata      = dat_q[READ_LATENCY-1];
    assign ram_readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_ext_ram_responder.sv
// Testbench for ext_ram_responder: two instances (one and zero wait states) share
// one stimulus stream. A cycle-level reference model built on a schedule of
// expected returns checks every output of both instances on every cycle.
module tb_ext_ram_responder;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int RL = 3;
    localparam int MP = 2;

    logic          clk = 1'b1;
    logic          reset;
    logic [AW-1:0] addr;
    logic [3:0]    be_n;
    logic          cs;
    logic [DW-1:0] wdata;
    logic          rn;
    logic          wn;
    logic [DW-1:0] rd0, rd1;
    logic          rdv0, rdv1, wr0, wr1;

    always #5 clk = ~clk;

    ext_ram_responder #(.RAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(1),
                        .READ_LATENCY(RL), .MAX_PENDING(MP)) u_dut0 (
        .clk(clk), .reset(reset), .ram_address(addr), .ram_byteenable_n(be_n),
        .ram_chipselect(cs), .ram_writedata(wdata), .ram_read_n(rn), .ram_write_n(wn),
        .ram_readdata(rd0), .ram_readdatavalid(rdv0), .ram_waitrequest(wr0));

    ext_ram_responder #(.RAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0),
                        .READ_LATENCY(RL), .MAX_PENDING(MP)) u_dut1 (
        .clk(clk), .reset(reset), .ram_address(addr), .ram_byteenable_n(be_n),
        .ram_chipselect(cs), .ram_writedata(wdata), .ram_read_n(rn), .ram_write_n(wn),
        .ram_readdata(rd1), .ram_readdatavalid(rdv1), .ram_waitrequest(wr1));

    int checks = 0;
    int errors = 0;

    // Reference model state, per instance.
    int          wmax [2] = '{1, 0};
    int          wc_m [2];
    bit          sv   [2][64];
    logic [31:0] sd   [2][64];
    logic [31:0] mem_m[2][16];
    int          cyc = 0;

    // Outputs observed in the most recent cycle.
    logic        lwr  [2];
    logic        lrdv [2];
    logic [31:0] lrd  [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        cs = 1'b0; rn = 1'b1; wn = 1'b1; be_n = 4'hF;
    endtask

    task automatic set_rd(input int a);
        cs = 1'b1; rn = 1'b0; wn = 1'b1; addr = AW'(a); be_n = 4'hF;
    endtask

    task automatic set_wr(input int a, input logic [31:0] d, input logic [3:0] be);
        cs = 1'b1; rn = 1'b1; wn = 1'b0; addr = AW'(a); wdata = d; be_n = be;
    endtask

    // One clock cycle: sample at the falling edge, compare with the model, advance the model.
    task automatic tick();
        bit cmd, iswr;
        bit acc [2];
        int pf, s0;
        @(negedge clk);
        lwr[0] = wr0; lrdv[0] = rdv0; lrd[0] = rd0;
        lwr[1] = wr1; lrdv[1] = rdv1; lrd[1] = rd1;
        cmd  = cs && (!rn || !wn);
        iswr = !wn;
        s0   = cyc % 64;
        for (int d = 0; d < 2; d++) begin
            pf = 0;
            for (int k = 1; k <= RL; k++) begin
                if (sv[d][(cyc + k) % 64]) pf++;
            end
            acc[d] = cmd && (wc_m[d] == wmax[d]) && (iswr || pf < MP) && !reset;
            check_eq($sformatf("waitreq%0d@%0d", d, cyc), 32'(lwr[d]), 32'(reset || (cmd && !acc[d])));
            if (cyc > 0) begin
                check_eq($sformatf("rdvalid%0d@%0d", d, cyc), 32'(lrdv[d]), 32'(sv[d][s0]));
                if (sv[d][s0]) check_eq($sformatf("rdata%0d@%0d", d, cyc), lrd[d], sd[d][s0]);
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            sv[d][s0] = 1'b0;
            if (reset) begin
                wc_m[d] = 0;
                for (int k = 0; k < 64; k++) sv[d][k] = 1'b0;
            end else begin
                if (acc[d]) wc_m[d] = 0;
                else if (cmd && wc_m[d] < wmax[d]) wc_m[d]++;
                if (acc[d] && iswr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (!be_n[b]) mem_m[d][addr[3:0]][8*b +: 8] = wdata[8*b +: 8];
                    end
                end else if (acc[d]) begin
                    sv[d][(cyc + RL) % 64] = 1'b1;
                    sd[d][(cyc + RL) % 64] = mem_m[d][addr[3:0]];
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle_ticks(input int n);
        set_idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    // Holds a write long enough for both instances to accept it.
    task automatic write_hold(input int a, input logic [31:0] d, input logic [3:0] be);
        set_wr(a, d, be);
        tick();
        tick();
        set_idle();
    endtask

    // Reads one word through instance d and checks the returned data.
    task automatic read_check(input int d, input int a, input logic [31:0] exp, input string tag);
        bit done = 1'b0;
        set_rd(a);
        for (int k = 0; k < 8 && !done; k++) begin
            tick();
            if (!lwr[d]) done = 1'b1;
        end
        set_idle();
        check_eq({tag, "_accepted"}, 32'(done), 32'd1);
        done = 1'b0;
        for (int k = 0; k < RL + 2 && !done; k++) begin
            tick();
            if (lrdv[d]) begin
                done = 1'b1;
                check_eq(tag, lrd[d], exp);
            end
        end
        check_eq({tag, "_returned"}, 32'(done), 32'd1);
    endtask

    initial begin : main
        int idx, nr, cnt, a_at;
        int acc_at [4];
        int rdv_at [4];
        logic [31:0] rdv_dat [4];
        int exp_acc [4] = '{0, 1, 3, 4};
        int exp_rdv [4] = '{3, 4, 6, 7};

        for (int d = 0; d < 2; d++) begin
            wc_m[d] = 0;
            for (int k = 0; k < 64; k++) begin sv[d][k] = 1'b0; sd[d][k] = 32'h0; end
        end
        addr = '0; wdata = 32'h0;

        // Reset held for three cycles with a read presented from cycle 0.
        reset = 1'b1;
        set_rd(0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_waitreq", 32'(lwr[0]), 32'd1);
            if (i > 0) begin
                check_eq("rst_rdata", lrd[0], 32'h0);
                check_eq("rst_rdvalid", 32'(lrdv[0]), 32'd0);
            end
        end
        reset = 1'b0;
        set_idle();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (lrdv[0] || lrdv[1]) cnt++;
        end
        check_eq("rst_no_return", 32'(cnt), 32'd0);

        // Fill the address window so every later read has defined contents.
        for (int a = 0; a < 16; a++) write_hold(a, 32'hC0DE0000 + 32'(a), 4'h0);
        idle_ticks(2);

        // Write then read on the one-wait-state instance, with exact timing.
        set_wr(5, 32'hDEADBEEF, 4'h0);
        tick(); check_eq("wr_wait", 32'(lwr[0]), 32'd1);
        tick(); check_eq("wr_accept", 32'(lwr[0]), 32'd0);
        set_rd(5);
        tick(); check_eq("rd_wait", 32'(lwr[0]), 32'd1);
        tick(); check_eq("rd_accept", 32'(lwr[0]), 32'd0);
        set_idle();
        tick(); check_eq("rd_lat1", 32'(lrdv[0]), 32'd0);
        tick(); check_eq("rd_lat2", 32'(lrdv[0]), 32'd0);
        tick(); check_eq("rd_lat3", 32'(lrdv[0]), 32'd1);
        check_eq("rd_data", lrd[0], 32'hDEADBEEF);
        tick(); check_eq("rd_once", 32'(lrdv[0]), 32'd0);
        idle_ticks(3);

        // Byte-enable merge.
        write_hold(7, 32'h11223344, 4'h0);
        write_hold(7, 32'hAABBCCDD, 4'b1010);
        read_check(0, 7, 32'h11BB33DD, "be_merge");
        idle_ticks(4);

        // Pending limit on the zero-wait-state instance: four back-to-back reads.
        idx = 0; nr = 0;
        for (int i = 0; i < 4; i++) begin acc_at[i] = -1; rdv_at[i] = -1; rdv_dat[i] = 32'h0; end
        for (int r = 0; r < 12; r++) begin
            if (idx < 4) set_rd(idx); else set_idle();
            tick();
            if (idx < 4 && !lwr[1]) begin acc_at[idx] = r; idx++; end
            if (lrdv[1] && nr < 4) begin rdv_at[nr] = r; rdv_dat[nr] = lrd[1]; nr++; end
        end
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("pend_accept%0d", i), 32'(acc_at[i]), 32'(exp_acc[i]));
            check_eq($sformatf("pend_return%0d", i), 32'(rdv_at[i]), 32'(exp_rdv[i]));
            check_eq($sformatf("pend_order%0d", i), rdv_dat[i], 32'hC0DE0000 + 32'(i));
        end
        idle_ticks(4);

        // Read and write asserted together behave as a write.
        cs = 1'b1; rn = 1'b0; wn = 1'b0; addr = AW'(9); wdata = 32'h12345678; be_n = 4'h0;
        tick(); tick();
        set_idle();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (lrdv[0] || lrdv[1]) cnt++;
        end
        check_eq("both_low_no_return", 32'(cnt), 32'd0);
        read_check(0, 9, 32'h12345678, "both_low_written");
        idle_ticks(4);

        // Reset one cycle after a read is accepted drops that read.
        set_rd(2);
        a_at = -1;
        for (int k = 0; k < 8 && a_at < 0; k++) begin
            tick();
            if (!lwr[0]) a_at = k;
        end
        check_eq("midrst_accepted", 32'(a_at >= 0), 32'd1);
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (lrdv[0]) cnt++;
        end
        check_eq("midrst_dropped", 32'(cnt), 32'd0);
        read_check(0, 5, 32'hDEADBEEF, "mem_keep5");
        read_check(0, 7, 32'h11BB33DD, "mem_keep7");
        idle_ticks(4);

        // Randomized traffic, including dropped commands and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            cs    = ($urandom_range(0, 3) != 0);
            rn    = 1'($urandom_range(0, 1));
            wn    = 1'($urandom_range(0, 1));
            addr  = AW'($urandom_range(0, 15));
            wdata = $urandom;
            be_n  = 4'($urandom_range(0, 15));
            tick();
        end
        reset = 1'b0;
        idle_ticks(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
